cp_latch_bank: RTL and testbench

Parametrised bank of set/clear pending latches for the TOM/JERRY interrupt and event-flag paths. It replaces discrete per-signal latch instances with one block of CHANNELS channels. Each channel adds per-channel edge/level capture, selectable set/clear priority, a sticky overflow flag, masking, and a priority-encoded vector with an acknowledge handshake. All state lives in `sys_clk`-domain flops with asynchronous clear.

---
 rtl/jag_pkg.sv | 17 +
 rtl/cp_latch_cell.sv | 46 ++++
 rtl/cp_latch_bank.sv | 64 ++++++
 tb/tb_cp_latch_bank.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/jag_pkg.sv
// Shared constants and helpers for the TOM/JERRY latch and event-flag blocks.
package jag_pkg;

  // Upper bound on the number of channels one latch bank may carry.
  localparam int CPL_MAX_CHANNELS = 32;

  // Ceiling log2, never below 1, so a single-channel bank still gets a 1-bit vector.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage : jag_pkg

// File: rtl/cp_latch_cell.sv
// One pending-latch channel: edge/level capture, set/clear priority, sticky overflow.
module cp_latch_cell #(
  parameter bit SET_WINS = 1'b0
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic set,
  input  logic clear,
  input  logic edge_mode,
  input  logic ack_clr,
  output logic q,
  output logic ovf
);

  logic r_set_d;
  logic r_q;
  logic r_ovf;
  logic w_set_eff;
  logic w_clr_eff;
  logic w_q_next;

  // Set event: rising edge of set in edge mode, raw level otherwise; set_d is shared by both modes.
  assign w_set_eff = edge_mode ? (set & ~r_set_d) : set;
  assign w_clr_eff = clear | ack_clr;
  assign w_q_next  = SET_WINS ? ((r_q & ~w_clr_eff) | w_set_eff)
                              : ((r_q | w_set_eff) & ~w_clr_eff);

  // Channel state: set history, pending flag and sticky overflow, all cleared asynchronously.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_set_d <= 1'b0;
      r_q     <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking here would let r_q see its own update.
      r_set_d <= set;
      r_q     <= w_q_next;
      // Overflow records a set event landing on an already-pending flag; only the bus clear drops it.
      r_ovf   <= clear ? 1'b0 : (r_ovf | (w_set_eff & r_q));
    end
  end

  assign q   = r_q;
  assign ovf = r_ovf;

endmodule : cp_latch_cell

// File: rtl/cp_latch_bank.sv
// Bank of CHANNELS pending latches with masked IRQ, lowest-index-first vector and ack handshake.
module cp_latch_bank
  import jag_pkg::*;
#(
  parameter int CHANNELS = 5,
  parameter bit SET_WINS = 1'b0
) (
  input  logic                                  sys_clk,
  input  logic                                  reset_n,
  input  logic [CHANNELS-1:0]                   set,
  input  logic [CHANNELS-1:0]                   clear,
  input  logic [CHANNELS-1:0]                   edge_mode,
  input  logic [CHANNELS-1:0]                   mask,
  input  logic                                  ack,
  output logic [CHANNELS-1:0]                   q,
  output logic [CHANNELS-1:0]                   ovf,
  output logic                                  irq,
  output logic [jag_pkg::clog2_min1(CHANNELS)-1:0] vec,
  output logic                                  vec_valid
);

  localparam int VW = clog2_min1(CHANNELS);

  logic [CHANNELS-1:0] w_pend;
  logic [CHANNELS-1:0] w_ack_clr;
  logic [VW-1:0]       w_vec;

  // One latch cell per channel; all channels update in parallel.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_cell
    cp_latch_cell #(
      .SET_WINS (SET_WINS)
    ) u_cell (
      .sys_clk   (sys_clk),
      .reset_n   (reset_n),
      .set       (set[g]),
      .clear     (clear[g]),
      .edge_mode (edge_mode[g]),
      .ack_clr   (w_ack_clr[g]),
      .q         (q[g]),
      .ovf       (ovf[g])
    );
  end

  assign w_pend = q & mask;

  // Lowest pending unmasked index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    // NOTE: default before the loop so every path assigns w_vec and no latch is inferred.
    w_vec = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_vec = VW'(i);
      end
    end
  end

  // Ack clears only the channel the vector currently points at; ignored when nothing is pending.
  assign w_ack_clr = (ack && (|w_pend)) ? (CHANNELS'(1) << w_vec) : '0;

  assign irq       = |w_pend;
  assign vec_valid = |w_pend;
  assign vec       = w_vec;

endmodule : cp_latch_bank

// File: tb/tb_cp_latch_bank.sv
// Directed self-checking bench for cp_latch_bank (CHANNELS=5, both SET_WINS settings).
module tb_cp_latch_bank;

  localparam int CH = 5;
  localparam int VW = 3;

  logic          sys_clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] set, clear, edge_mode, mask;
  logic          ack;
  logic [CH-1:0] q0, ovf0, q1, ovf1;
  logic          irq0, vv0, irq1, vv1;
  logic [VW-1:0] vec0, vec1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  cp_latch_bank #(.CHANNELS(CH), .SET_WINS(1'b0)) dut0 (
    .sys_clk(sys_clk), .reset_n(reset_n), .set(set), .clear(clear),
    .edge_mode(edge_mode), .mask(mask), .ack(ack),
    .q(q0), .ovf(ovf0), .irq(irq0), .vec(vec0), .vec_valid(vv0)
  );

  cp_latch_bank #(.CHANNELS(CH), .SET_WINS(1'b1)) dut1 (
    .sys_clk(sys_clk), .reset_n(reset_n), .set(set), .clear(clear),
    .edge_mode(edge_mode), .mask(mask), .ack(ack),
    .q(q1), .ovf(ovf1), .irq(irq1), .vec(vec1), .vec_valid(vv1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    set       = 5'h1F;
    clear     = '0;
    edge_mode = '0;
    mask      = 5'h1F;
    ack       = 1'b0;

    // Reset holds everything at zero despite set being high.
    tick(); tick();
    check("rst_q",   q0,   0);
    check("rst_ovf", ovf0, 0);
    check("rst_irq", irq0, 0);
    check("rst_vec", vec0, 0);
    check("rst_vv",  vv0,  0);
    set = '0;
    reset_n = 1'b1;
    tick();
    check("post_rst_q", q0, 0);

    // Level capture then bus clear.
    set = 5'b00100; tick(); set = '0;
    check("lvl_q",   q0,   5'b00100);
    check("lvl_irq", irq0, 1);
    check("lvl_vec", vec0, 2);
    clear = 5'b00100; tick(); clear = '0;
    check("clr_q",   q0,   0);
    check("clr_irq", irq0, 0);

    // Priority and back-to-back acks.
    set = 5'b10110; tick(); set = '0;
    check("pri_q",   q0,   5'b10110);
    check("pri_vec", vec0, 1);
    ack = 1'b1;
    tick();
    check("ack1_q",   q0,   5'b10100);
    check("ack1_vec", vec0, 2);
    tick();
    check("ack2_q",   q0,   5'b10000);
    check("ack2_vec", vec0, 4);
    tick();
    check("ack3_q",  q0,  0);
    check("ack3_vv", vv0, 0);
    tick();
    check("ack4_q",   q0,   0);
    check("ack4_irq", irq0, 0);
    check("ack_ovf",  ovf0, 0);
    ack = 1'b0;

    // Edge mode on channel 0: set held 4 cycles, clear in cycle 2.
    edge_mode = 5'b00001;
    set = 5'b00001;
    tick();                      check("edg_c0", q0[0], 1);
    tick();                      check("edg_c1", q0[0], 1);
    clear = 5'b00001; tick(); clear = '0;
                                 check("edg_c2", q0[0], 0);
    tick();                      check("edg_c3", q0[0], 0);
    set = '0; tick();

    // Same stimulus in level mode: flag comes back right after the clear.
    edge_mode = '0;
    set = 5'b00001;
    tick();                      check("lv_c0", q0[0], 1);
    tick();                      check("lv_c1", q0[0], 1);
                                 check("lv_c1_ovf", ovf0[0], 1);
    clear = 5'b00001; tick(); clear = '0;
                                 check("lv_c2", q0[0], 0);
                                 check("lv_c2_ovf", ovf0[0], 0);
    tick();                      check("lv_c3", q0[0], 1);
                                 check("lv_c3_ovf", ovf0[0], 0);
    set = '0;
    clear = 5'h1F; tick(); clear = '0;
    check("clean_q0", q0, 0);
    check("clean_q1", q1, 0);

    // Set/clear collision on channel 3.
    set = 5'b01000; clear = 5'b01000; tick();
    set = '0; clear = '0;
    check("col_sw0", q0[3], 0);
    check("col_sw1", q1[3], 1);
    check("col_ovf1", ovf1, 0);
    clear = 5'h1F; tick(); clear = '0;

    // Ack colliding with a new set on the same channel (channel 2 at vec).
    set = 5'b00100; tick();
    ack = 1'b1; tick(); ack = 1'b0; set = '0;
    check("ackcol_sw0", q0[2], 0);
    check("ackcol_sw1", q1[2], 1);
    clear = 5'h1F; tick(); clear = '0;

    // Overflow on channel 1.
    set = 5'b00010; tick(); set = '0; tick();
    check("ovf_pre_q",   q0,   5'b00010);
    check("ovf_pre_ovf", ovf0, 0);
    set = 5'b00010; tick(); set = '0;
    check("ovf_set", ovf0, 5'b00010);
    ack = 1'b1; tick(); ack = 1'b0;
    check("ovf_ack_q",   q0,   0);
    check("ovf_ack_ovf", ovf0, 5'b00010);
    clear = 5'b00010; tick(); clear = '0;
    check("ovf_clr_q",   q0,   0);
    check("ovf_clr_ovf", ovf0, 0);

    // Masking is combinational and never touches q.
    set = 5'b01000; tick(); set = '0;
    mask = '0; #1;
    check("msk_irq", irq0, 0);
    check("msk_vv",  vv0,  0);
    check("msk_vec", vec0, 0);
    tick();
    check("msk_q", q0, 5'b01000);
    mask = 5'b01000; #1;
    check("unmsk_irq", irq0, 1);
    check("unmsk_vec", vec0, 3);
    mask = 5'h1F;

    // Asynchronous reset mid-cycle, during an acknowledge.
    clear = 5'h1F; tick(); clear = '0;
    set = 5'b01010; tick(); set = '0;
    check("pre_arst_q", q0, 5'b01010);
    ack = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("arst_q",   q0,   0);
    check("arst_ovf", ovf0, 0);
    check("arst_irq", irq0, 0);
    check("arst_vec", vec0, 0);
    check("arst_vv",  vv0,  0);
    ack = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("arst_hold_q", q0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cp_latch_bank
